tff_cnt_seq: RTL and testbench

//  Measurement sequencer for a ripple counter built from a chain of toggle flip-flops.

---
 rtl/tff_seq_pkg.sv | 25 ++
 rtl/tff_seq_sync2.sv | 36 +++
 rtl/tff_cnt_seq.sv | 190 +++++++++++++++++++
 tb/tb_tff_cnt_seq.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tff_seq_pkg
// Description : Shared types and constants for the TFF ripple-counter
//               measurement sequencer (state encoding, clear length).
// Revision    : 1.0 - initial release
// ============================================================================
package tff_seq_pkg;

  // Sequencer states; 3-bit encoding shared by all users of the package.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ARM    = 3'd2,
    COUNT  = 3'd3,
    SETTLE = 3'd4,
    HOLD   = 3'd5
  } tff_seq_state_t;

  // Number of clk cycles the TFF chain is held in reset before arming.
  localparam int CLR_CYC = 2;

endpackage : tff_seq_pkg
`default_nettype wire

// File: rtl/tff_seq_sync2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tff_seq_sync2
// Description : Two-flop synchronizer for a single asynchronous bit,
//               asynchronous active-low reset to 0.
// Ports       : clk     - destination clock
//               reset_n - asynchronous reset, active low
//               d       - asynchronous input bit
//               q       - synchronized output bit
// Revision    : 1.0 - initial release
// ============================================================================
module tff_seq_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : tff_seq_sync2
`default_nettype wire

// File: rtl/tff_cnt_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tff_cnt_seq
// Description : Measurement sequencer for a ripple counter built from a chain
//               of toggle flip-flops. Clears the chain, opens the counting
//               gate for a programmed window, lets the ripple settle, captures
//               the count and offers it to readout with valid/ready.
// Config      : TFF_SEQ_OVF_EN - when defined, the counter MSB is
//               synchronized and a wrap during the window saturates the
//               captured count and raises data_ovf. When undefined, data is
//               the raw wrapped count and data_ovf is always 0.
// Ports       : clk        - master clock
//               reset_n    - asynchronous reset, active low
//               start      - begin measurement (sampled only in IDLE)
//               abort      - cancel measurement, return to IDLE
//               window_len - gate-open length in clk cycles (latched on start)
//               cnt_q      - TFF chain Q outputs (asynchronous to clk)
//               cnt_gate   - enables events into the first TFF
//               cnt_clr_n  - TFF chain reset, active low
//               busy       - high in every state except IDLE
//               data       - captured count
//               data_ovf   - counter wrapped during window
//               data_valid - data/data_ovf valid
//               data_ready - consumer accepts data
// Revision    : 1.0 - initial release
// ============================================================================
module tff_cnt_seq
  import tff_seq_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             cnt_gate,
  output logic             cnt_clr_n,
  output logic             busy,
  output logic [CNT_W-1:0] data,
  output logic             data_ovf,
  output logic             data_valid,
  input  logic             data_ready
);

  localparam int c_SET_W = $clog2(SETTLE_CYC + 1);

  tff_seq_state_t   r_state;
  logic [WIN_W-1:0] r_win;      // window length latched on accepted start
  logic [WIN_W-1:0] r_win_cnt;  // down-counter shared by CLEAR and COUNT
  logic [c_SET_W-1:0] r_set_cnt;

  logic [CNT_W-1:0] w_cap_data;
  logic             w_cap_ovf;

`ifdef TFF_SEQ_OVF_EN
  logic w_msb_sync;
  logic r_msb_d;
  logic r_ovf;
  logic w_msb_fall;

  tff_seq_sync2 u_msb_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (cnt_q[CNT_W-1]),
    .q       (w_msb_sync)
  );

  assign w_msb_fall = r_msb_d & ~w_msb_sync;

  // Sticky wrap flag: only falls of the MSB while events can still be in
  // flight count; the fall caused by clearing the chain happens before COUNT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msb_d <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_msb_d <= w_msb_sync;
      if (r_state == CLEAR) begin
        r_ovf <= 1'b0;
      end else if ((r_state == COUNT || r_state == SETTLE) && w_msb_fall) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_cap_data = r_ovf ? {CNT_W{1'b1}} : cnt_q;
  assign w_cap_ovf  = r_ovf;
`else
  assign w_cap_data = cnt_q;
  assign w_cap_ovf  = 1'b0;
`endif

  // cnt_q is sampled only on the last SETTLE cycle, after the gate has been
  // closed for SETTLE_CYC cycles, so the ripple is quiescent and no
  // synchronizer is needed on the data path.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_win      <= '0;
      r_win_cnt  <= '0;
      r_set_cnt  <= '0;
      cnt_gate   <= 1'b0;
      cnt_clr_n  <= 1'b0;
      busy       <= 1'b0;
      data       <= '0;
      data_ovf   <= 1'b0;
      data_valid <= 1'b0;
    end else if (r_state != IDLE && abort) begin
      // data/data_ovf deliberately keep their last captured values.
      r_state    <= IDLE;
      cnt_gate   <= 1'b0;
      cnt_clr_n  <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state   <= CLEAR;
            r_win     <= window_len;
            r_win_cnt <= WIN_W'(CLR_CYC - 1);
            busy      <= 1'b1;
          end
        end

        CLEAR: begin
          if (r_win_cnt == '0) begin
            r_state   <= ARM;
            cnt_clr_n <= 1'b1;
          end else begin
            r_win_cnt <= r_win_cnt - WIN_W'(1);
          end
        end

        // One idle cycle with the chain released gives reset-recovery margin
        // before the first event can arrive.
        ARM: begin
          r_state   <= COUNT;
          cnt_gate  <= 1'b1;
          r_win_cnt <= (r_win == '0) ? '0 : (r_win - WIN_W'(1));
        end

        COUNT: begin
          if (r_win_cnt == '0) begin
            r_state   <= SETTLE;
            cnt_gate  <= 1'b0;
            r_set_cnt <= c_SET_W'(SETTLE_CYC - 1);
          end else begin
            r_win_cnt <= r_win_cnt - WIN_W'(1);
          end
        end

        SETTLE: begin
          if (r_set_cnt == '0) begin
            r_state    <= HOLD;
            data       <= w_cap_data;
            data_ovf   <= w_cap_ovf;
            data_valid <= 1'b1;
          end else begin
            r_set_cnt <= r_set_cnt - c_SET_W'(1);
          end
        end

        HOLD: begin
          if (data_ready) begin
            r_state    <= IDLE;
            data_valid <= 1'b0;
            cnt_clr_n  <= 1'b0;
            busy       <= 1'b0;
          end
        end

        default: begin
          r_state    <= IDLE;
          cnt_gate   <= 1'b0;
          cnt_clr_n  <= 1'b0;
          busy       <= 1'b0;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : tff_cnt_seq
`default_nettype wire

// File: tb/tb_tff_cnt_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tff_cnt_seq
// Description : Self-checking bench for tff_cnt_seq. A behavioural TFF ripple
//               chain is fed by an event source gated by cnt_gate; expected
//               latency, gate length and captured count come from a simple
//               arithmetic model of the measurement.
// Config      : honours TFF_SEQ_OVF_EN for the expected captured values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_cnt_seq;

  localparam int CNT_W      = 4;
  localparam int WIN_W      = 16;
  localparam int SETTLE_CYC = 4;
  localparam int CLR_CYC    = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             data_ready = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_gate;
  logic             cnt_clr_n;
  logic             busy;
  logic [CNT_W-1:0] data;
  logic             data_ovf;
  logic             data_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tff_cnt_seq #(
    .CNT_W      (CNT_W),
    .WIN_W      (WIN_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .window_len (window_len),
    .cnt_q      (cnt_q),
    .cnt_gate   (cnt_gate),
    .cnt_clr_n  (cnt_clr_n),
    .busy       (busy),
    .data       (data),
    .data_ovf   (data_ovf),
    .data_valid (data_valid),
    .data_ready (data_ready)
  );

  // ---------------- behavioural ripple counter ----------------
  logic ev = 1'b0;
  logic tff_b [CNT_W] = '{default: 1'b0};

  always @(posedge ev or negedge cnt_clr_n) begin
    if (!cnt_clr_n) tff_b[0] <= 1'b0;
    else            tff_b[0] <= ~tff_b[0];
  end
  assign cnt_q[0] = tff_b[0];

  for (genvar gi = 1; gi < CNT_W; gi++) begin : g_tff
    always @(negedge tff_b[gi-1] or negedge cnt_clr_n) begin
      if (!cnt_clr_n) tff_b[gi] <= 1'b0;
      else            tff_b[gi] <= ~tff_b[gi];
    end
    assign cnt_q[gi] = tff_b[gi];
  end

  // Event source: one pulse per gate-open cycle until ev_left is spent.
  int ev_left = 0;
  always @(posedge clk) begin
    #2;
    if (cnt_gate && ev_left > 0) begin
      ev_left = ev_left - 1;
      ev = 1'b1;
      #2 ev = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int exp_lat(input int w);
    return CLR_CYC + 1 + ((w == 0) ? 1 : w) + SETTLE_CYC;
  endfunction

  function automatic int exp_gate(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit exp_ovf(input int n);
`ifdef TFF_SEQ_OVF_EN
    return n >= (1 << CNT_W);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_data(input int n);
    if (exp_ovf(n)) return (1 << CNT_W) - 1;
    return n % (1 << CNT_W);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one measurement from start to data_valid. Called at #1 after an edge.
  task automatic run_meas(input int w, input int nev, input bit poke_start,
                          output int lat, output int gate_n);
    bit poked;
    poked      = 1'b0;
    lat        = 0;
    gate_n     = 0;
    window_len = WIN_W'(w);
    ev_left    = nev;
    start      = 1'b1;
    @(posedge clk); #1;                       // edge e0
    start      = 1'b0;
    window_len = WIN_W'($urandom);            // must be ignored while busy
    check("busy_after_start", 32'(busy), 32'd1);
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cnt_gate) begin
        gate_n++;
        if (poke_start && !poked) begin
          start = 1'b1;
          poked = 1'b1;
        end
      end
      if (data_valid) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Holds ready low for hold_cyc cycles checking stability, then accepts.
  task automatic handshake(input int hold_cyc, input int exp_d);
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(data_valid), 32'd1);
      check("hold_data", 32'(data), 32'(exp_d));
    end
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    check("rel_valid", 32'(data_valid), 32'd0);
    check("rel_clr_n", 32'(cnt_clr_n), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);
  endtask

  task automatic meas_and_check(input string tag, input int w, input int nev,
                                input bit poke, input int hold_cyc);
    int lat, gate_n;
    run_meas(w, nev, poke, lat, gate_n);
    $display("INFO %s: w=%0d events=%0d latency=%0d gate=%0d", tag, w, nev, lat, gate_n);
    check("latency", 32'(lat), 32'(exp_lat(w)));
    check("gate_cycles", 32'(gate_n), 32'(exp_gate(w)));
    check("data", 32'(data), 32'(exp_data(nev)));
    check("data_ovf", 32'(data_ovf), 32'(exp_ovf(nev)));
    handshake(hold_cyc, exp_data(nev));
  endtask

  initial begin
    int gate_n, vcount, w, nev;

    // 1. reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_gate", 32'(cnt_gate), 32'd0);
    check("rst_clr_n", 32'(cnt_clr_n), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ovf", 32'(data_ovf), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 2 + 3. basic window, held in HOLD for 5 cycles
    meas_and_check("basic", 10, 7, 1'b0, 5);

    // 4. abort during the 5th COUNT cycle
    window_len = WIN_W'(20);
    ev_left    = 20;
    start      = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    gate_n = 0;
    for (int k = 0; k < 40 && gate_n < 5; k++) begin
      @(posedge clk); #1;
      if (cnt_gate) gate_n++;
    end
    check("abort_reached_count", 32'(gate_n), 32'd5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort   = 1'b0;
    ev_left = 0;
    check("abort_gate", 32'(cnt_gate), 32'd0);
    check("abort_clr_n", 32'(cnt_clr_n), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data_kept", 32'(data), 32'd7);
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (data_valid) vcount++;
    end
    check("abort_no_valid", 32'(vcount), 32'd0);

    // 5. zero window with a start pulse during COUNT
    meas_and_check("zero_win", 0, 1, 1'b1, 0);
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (data_valid || busy) vcount++;
    end
    check("no_second_meas", 32'(vcount), 32'd0);

    // 6. counter wrap
    meas_and_check("wrap", 25, 20, 1'b0, 1);

    // randomized measurements
    for (int it = 0; it < 12; it++) begin
      w   = int'($urandom_range(0, 40));
      nev = int'($urandom_range(0, exp_gate(w)));
      meas_and_check("rand", w, nev, 1'b0, int'($urandom_range(0, 3)));
    end

    // asynchronous reset in the middle of COUNT
    window_len = WIN_W'(12);
    ev_left    = 12;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_gate", 32'(cnt_gate), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_data", 32'(data), 32'd0);
    ev_left = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    meas_and_check("post_reset", 3, 3, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule : tb_tff_cnt_seq
`default_nettype wire
